// File: rtl/mest_result_collector.sv
// -----------------------------------------------------------------------------
// mest_result_collector
//
// Purpose:
//   Sits downstream of the mest_pro core. Every result the core flags valid is
//   captured, together with its carry and zero flags, into a first-word-fall-
//   through FIFO. The FIFO is drained to a host/UART-side consumer over a
//   valid/ready handshake. End of program (i_all_done) moves the collector into
//   a drain phase; the final drained entry is flagged with o_last and overall
//   completion with o_done.
//
// Ports:
//   clk             in   single clock, rising edge
//   i_reset         in   asynchronous, active-high reset
//   i_clear         in   synchronous clear (core memory-reset request)
//   i_arm           in   one-cycle pulse (core start); opens a collection run
//   i_result        in   core result, DATA_WIDTH bits
//   i_valid_result  in   qualifies i_result / i_carry / i_zero_flag
//   i_carry         in   carry flag for this result
//   i_zero_flag     in   zero flag for this result
//   i_all_done      in   core finished the program (level or pulse)
//   o_data          out  FIFO head, packed {carry, zero, result}
//   o_data_valid    out  head entry present
//   i_data_ready    in   consumer accepts the head entry
//   o_last          out  head is the final entry of the run
//   o_fifo_count    out  current occupancy, 0..FIFO_DEPTH
//   o_result_total  out  results accepted this run, saturating
//   o_overflow      out  sticky: a result was dropped on a full FIFO
//   o_done          out  run complete and FIFO drained
// -----------------------------------------------------------------------------
module mest_result_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,   // power of two, >= 2
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          i_reset,
   input  logic                          i_clear,
   input  logic                          i_arm,
   input  logic [DATA_WIDTH-1:0]         i_result,
   input  logic                          i_valid_result,
   input  logic                          i_carry,
   input  logic                          i_zero_flag,
   input  logic                          i_all_done,
   output logic [DATA_WIDTH+1:0]         o_data,
   output logic                          o_data_valid,
   input  logic                          i_data_ready,
   output logic                          o_last,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic [CNT_WIDTH-1:0]          o_result_total,
   output logic                          o_overflow,
   output logic                          o_done
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int ENTRY_W = DATA_WIDTH + 2;

   localparam logic [OCC_W-1:0]     FULL_OCC  = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0]     ONE_OCC   = OCC_W'(1);
   localparam logic [PTR_W-1:0]     ONE_PTR   = PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] ONE_TOTAL = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DRAIN,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 state_q,      state_d;
   logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
   logic [OCC_W-1:0]       count_q,      count_d;
   logic [CNT_WIDTH-1:0]   total_q,      total_d;
   logic                   overflow_q,   overflow_d;
   logic                   done_q,       done_d;
   logic [ENTRY_W-1:0]     data_hold_q,  data_hold_d;

   logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   pop;
   logic                   push_req;
   logic                   push_ok;
   logic [ENTRY_W-1:0]     wr_entry;
   logic [ENTRY_W-1:0]     head_entry;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_OCC);
   assign head_entry = mem_q[rd_ptr_q];
   assign wr_entry   = {i_carry, i_zero_flag, i_result};

   // Ready is ignored while empty, so a pop needs a present head.
   assign pop        = !fifo_empty && i_data_ready;
   assign push_req   = (state_q == S_COLLECT) && i_valid_result;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push_ok    = push_req && (!fifo_full || pop) && !i_clear;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      total_d     = total_q;
      overflow_d  = overflow_q;
      data_hold_d = data_hold_q;

      // Remember the last head shown so o_data keeps its value once empty.
      if (!fifo_empty) begin
         data_hold_d = head_entry;
      end

      if (i_clear) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         total_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
         end

         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
            if (total_q != '1) begin
               total_d = total_q + ONE_TOTAL;
            end
         end else if (push_req) begin
            overflow_d = 1'b1;
         end

         unique case ({push_ok, pop})
            2'b10:   count_d = count_q + ONE_OCC;
            2'b01:   count_d = count_q - ONE_OCC;
            default: count_d = count_q;
         endcase

         // Pushes only happen in COLLECT and arm only acts in IDLE/DONE, so
         // the counter updates above never collide with the arm restart.
         unique case (state_q)
            S_IDLE: begin
               if (i_arm) begin
                  state_d    = S_COLLECT;
                  total_d    = '0;
                  overflow_d = 1'b0;
               end
            end
            S_COLLECT: begin
               // A result arriving with i_all_done was already pushed above.
               if (i_all_done) begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Looking at the post-edge occupancy lets o_done rise the cycle
               // right after the last pop.
               if (count_d == '0) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (i_arm) begin
                  state_d    = S_COLLECT;
                  total_d    = '0;
                  overflow_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      done_d = (state_d == S_DONE);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         total_q     <= '0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         total_q     <= total_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
         data_hold_q <= data_hold_d;
      end
   end

   // NOTE: the storage array is not reset; occupancy gates every read, so its
   // contents are never observed before being written, and it maps to RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Head is combinational so a newly written entry shows one cycle after
   // capture and back-to-back pops have no bubble.
   assign o_data         = fifo_empty ? data_hold_q : head_entry;
   assign o_data_valid   = !fifo_empty;
   assign o_last         = (state_q == S_DRAIN) && (count_q == ONE_OCC);
   assign o_fifo_count   = count_q;
   assign o_result_total = total_q;
   assign o_overflow     = overflow_q;
   assign o_done         = done_q;

endmodule

// File: doc/mest_result_collector.md
Name: mest_result_collector

Overview:
- Sits directly downstream of the mest_pro core.
- Captures every result the core flags valid, together with that result's carry and zero flags, into a first-word-fall-through FIFO.
- Drains the FIFO to a host or UART-side consumer over a valid/ready handshake.
- Tracks end of program (i_all_done) and flags the final drained entry and overall completion.

Parameters:
- DATA_WIDTH, 8, width of i_result; entry width is DATA_WIDTH+2.
- FIFO_DEPTH, 16, number of entries; must be a power of two, at least 2.
- CNT_WIDTH, 16, width of the saturating accepted-result counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous clear; tied to the core's memory-reset request.
- i_arm  in  1  one-cycle pulse; tied to the core's start; opens a collection run.
- i_result  in  DATA_WIDTH  core result byte.
- i_valid_result  in  1  qualifies i_result, i_carry and i_zero_flag for one cycle.
- i_carry  in  1  carry flag for this result.
- i_zero_flag  in  1  zero flag for this result.
- i_all_done  in  1  core has finished the program; level or pulse.
- o_data  out  DATA_WIDTH+2  FIFO head, packed as {carry, zero, result}.
- o_data_valid  out  1  head entry is present.
- i_data_ready  in  1  consumer accepts the head entry.
- o_last  out  1  head is the final entry of the run.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_result_total  out  CNT_WIDTH  results accepted this run; saturates at all-ones.
- o_overflow  out  1  sticky: at least one result was dropped because the FIFO was full.
- o_done  out  1  run complete and FIFO fully drained.

Behaviour:
- Reset (i_reset=1, asynchronous): state IDLE; pointers and count cleared; all outputs 0, including o_data.
- Priority each cycle: i_clear over i_arm over all other activity.
- i_clear: flushes FIFO; zeroes o_result_total and o_overflow; state goes to IDLE on the next edge.
- States:
  - IDLE: pushes ignored; i_arm -> COLLECT.
  - COLLECT: i_valid_result pushes an entry; i_all_done -> DRAIN. If i_valid_result and i_all_done occur in the same cycle, the entry is pushed before the transition.
  - DRAIN: pushes ignored; transitions to DONE when count==0 and no push is pending.
  - DONE: o_done=1; i_arm -> COLLECT.
- i_arm in DONE or IDLE: zeroes o_result_total and o_overflow. FIFO contents are preserved; in DONE the FIFO is already empty.
- i_arm in COLLECT or DRAIN: ignored.
- Push (COLLECT and i_valid_result):
  - Writes {i_carry, i_zero_flag, i_result} at the write pointer.
  - Increments o_result_total, saturating.
  - Entry is visible on o_data/o_data_valid on the cycle after the capture edge (1-cycle latency).
- Pop: occurs when o_data_valid && i_data_ready; read pointer advances at the edge. o_data and o_data_valid are combinational from the head, so they are valid with no bubble.
- Full:
  - Push with no pop: entry dropped; o_overflow set; o_result_total not incremented.
  - Push and pop in the same cycle: push accepted; count unchanged.
- Empty:
  - o_data_valid=0 and o_last=0.
  - o_data holds its last value and is don't-care.
  - i_data_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- o_last = (state==DRAIN) && (count==1).
- o_done is registered; it asserts the cycle after the last pop, or the cycle after entering DRAIN with an empty FIFO.
- Reset mid-run: all state is lost immediately, with no drain.

Test Plan:
- Reset, then i_arm; three pushes 0x05/c0z0, 0x00/c0z1, 0xFF/c1z0 with i_data_ready=1 -> o_data sequence 0x005, 0x100, 0x2FF, each 1 cycle after capture; o_result_total=3.
- i_data_ready=0; 17 pushes with DEPTH=16 -> o_fifo_count=16, o_overflow=1, o_result_total=16. Then drain -> first 16 values in order; 17th absent.
- FIFO full, then push and pop in the same cycle -> count stays 16, o_overflow stays 0, new entry appears last.
- Push 0x2A together with i_all_done, i_data_ready=0 -> next cycle state DRAIN, count=1, o_last=1. Assert ready -> 0x02A popped; o_done=1 on the following cycle.
- i_clear mid-COLLECT with count=5 -> next cycle count=0, o_data_valid=0, o_result_total=0, state IDLE; subsequent i_valid_result ignored.
- i_reset pulsed asynchronously between edges mid-DRAIN -> all outputs 0 immediately, without waiting for a clock edge.
